// File: rtl/wb_scoreboard_if.sv
// wb_scoreboard_if: issue, flush and delayed-writeback signals of the
// writeback scoreboard. master = decode/control side, slave = scoreboard.
//   flush, issue_*          master -> slave
//   stall, wb_*, count      slave  -> master
interface wb_scoreboard_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          flush;
    logic          issue_valid;
    logic [1:0]    issue_kind;
    logic          issue_we;
    logic [4:0]    issue_rd;
    logic [4:0]    issue_rs1;
    logic [4:0]    issue_rs2;
    logic          issue_use_rs1;
    logic          issue_use_rs2;
    logic [2:0]    issue_sx_size;
    logic          stall;
    logic          wb_valid;
    logic [4:0]    wb_rd;
    logic [1:0]    wb_kind;
    logic [2:0]    wb_sx_size;
    logic [CW-1:0] count;

    modport master (
        output flush, issue_valid, issue_kind, issue_we, issue_rd,
        output issue_rs1, issue_rs2, issue_use_rs1, issue_use_rs2,
        output issue_sx_size,
        input  stall, wb_valid, wb_rd, wb_kind, wb_sx_size, count
    );

    modport slave (
        input  flush, issue_valid, issue_kind, issue_we, issue_rd,
        input  issue_rs1, issue_rs2, issue_use_rs1, issue_use_rs2,
        input  issue_sx_size,
        output stall, wb_valid, wb_rd, wb_kind, wb_sx_size, count
    );
endinterface

// File: rtl/wb_scoreboard.sv
// wb_scoreboard: in-order tracker of outstanding multi-cycle register
// writes (loads, crypto ops) with RAW/WAW/capacity/port stall generation.
// Ports: clk, rst (async active-low), sb (wb_scoreboard_if.slave):
//   flush, issue_* in; stall (comb), wb_valid/wb_rd/wb_kind/wb_sx_size
//   (comb from head entry), count (registered) out.
// Option: WB_SCOREBOARD_BYPASS_EN lets the retiring head be ignored for
// hazards and frees its slot for a same-cycle allocation.
module wb_scoreboard #(
    parameter int DEPTH      = 4,
    parameter int CNT_W      = 4,
    parameter int LOAD_LAT   = 1,
    parameter int CRYPTO_LAT = 2
) (
    input  logic           clk,
    input  logic           rst,
    wb_scoreboard_if.slave sb
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CW    = PTR_W + 1;

    logic [DEPTH-1:0] e_valid;
    logic [4:0]       e_rd   [DEPTH];
    logic [1:0]       e_kind [DEPTH];
    logic [2:0]       e_sx   [DEPTH];
    logic [CNT_W-1:0] e_cnt  [DEPTH];

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CW-1:0]    count_q;

    logic             head_ready;
    logic             retire;
    logic             alloc;
    logic             is_delayed;
    logic [CNT_W-1:0] lat;
    logic [DEPTH-1:0] live;
    logic             hit_rs1;
    logic             hit_rs2;
    logic             hit_rd;
    logic             raw;
    logic             waw;
    logic             full;
    logic             port;
    logic             stall;

    // cnt holds the cycles still to wait after the cycle following
    // acceptance, so a latency of L gives writeback L cycles after issue.
    always_comb begin
        is_delayed = 1'b0;
        lat        = '0;
        unique case (sb.issue_kind)
            2'b01: begin
                is_delayed = 1'b1;
                lat        = CNT_W'(LOAD_LAT - 1);
            end
            2'b10: begin
                is_delayed = 1'b1;
                lat        = CNT_W'(CRYPTO_LAT - 1);
            end
            default: begin
                is_delayed = 1'b0;
                lat        = '0;
            end
        endcase
    end

    always_comb begin
        head_ready = e_valid[head] && (e_cnt[head] == '0);
        live       = e_valid;
`ifdef WB_SCOREBOARD_BYPASS_EN
        // Retiring data is forwarded by the datapath.
        if (head_ready) begin
            live[head] = 1'b0;
        end
`endif
        hit_rs1 = 1'b0;
        hit_rs2 = 1'b0;
        hit_rd  = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (live[i]) begin
                if (e_rd[i] == sb.issue_rs1) hit_rs1 = 1'b1;
                if (e_rd[i] == sb.issue_rs2) hit_rs2 = 1'b1;
                if (e_rd[i] == sb.issue_rd)  hit_rd  = 1'b1;
            end
        end
    end

    always_comb begin
        raw = (sb.issue_use_rs1 && (sb.issue_rs1 != 5'd0) && hit_rs1)
           || (sb.issue_use_rs2 && (sb.issue_rs2 != 5'd0) && hit_rs2);
        waw = sb.issue_we && (sb.issue_rd != 5'd0) && hit_rd;
`ifdef WB_SCOREBOARD_BYPASS_EN
        full = is_delayed && (count_q == CW'(DEPTH)) && !head_ready;
`else
        full = is_delayed && (count_q == CW'(DEPTH));
`endif
        // The delayed path owns the register-file port when it retires.
        port   = !is_delayed && sb.issue_we && head_ready;
        stall  = sb.issue_valid && !sb.flush
              && (raw || waw || full || port);
        retire = head_ready && !sb.flush;
        alloc  = sb.issue_valid && !stall && !sb.flush && sb.issue_we
              && (sb.issue_rd != 5'd0) && is_delayed;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            e_valid <= '0;
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                e_rd[i]   <= '0;
                e_kind[i] <= '0;
                e_sx[i]   <= '0;
                e_cnt[i]  <= '0;
            end
        end else if (sb.flush) begin
            e_valid <= '0;
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (e_valid[i] && (e_cnt[i] != '0)) begin
                    e_cnt[i] <= e_cnt[i] - CNT_W'(1);
                end
            end
            if (retire) begin
                e_valid[head] <= 1'b0;
                head          <= head + PTR_W'(1);
            end
            // Placed after the pop so a full-queue bypass allocation into
            // the slot being freed wins.
            if (alloc) begin
                e_valid[tail] <= 1'b1;
                e_rd[tail]    <= sb.issue_rd;
                e_kind[tail]  <= sb.issue_kind;
                e_sx[tail]    <= sb.issue_sx_size;
                e_cnt[tail]   <= lat;
                tail          <= tail + PTR_W'(1);
            end
            count_q <= count_q + CW'(alloc) - CW'(retire);
        end
    end

    assign sb.stall      = stall;
    assign sb.wb_valid   = retire;
    assign sb.wb_rd      = e_rd[head];
    assign sb.wb_kind    = e_kind[head];
    assign sb.wb_sx_size = e_sx[head];
    assign sb.count      = count_q;
endmodule

// File: tb/tb_wb_scoreboard.sv
// tb_wb_scoreboard: directed scenarios plus random issue streams checked
// against a queue model that tracks absolute writeback-ready cycles.
module tb_wb_scoreboard;
    localparam int DEPTH = 4;
    localparam int CNT_W = 4;
    localparam int LL    = 1;
    localparam int CL    = 6;
    localparam int CW    = $clog2(DEPTH) + 1;
`ifdef WB_SCOREBOARD_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    wb_scoreboard_if #(.DEPTH(DEPTH)) bus();

    wb_scoreboard #(
        .DEPTH(DEPTH), .CNT_W(CNT_W),
        .LOAD_LAT(LL), .CRYPTO_LAT(CL)
    ) dut (
        .clk(clk),
        .rst(rst),
        .sb(bus)
    );

    typedef struct {
        logic [4:0] rd;
        logic [1:0] kind;
        logic [2:0] sx;
        int         ready;
    } ent_t;

    ent_t mq[$];
    int   cyc    = 0;
    int   checks = 0;
    int   fails  = 0;

    logic       e_stall;
    logic       e_wb;
    logic [4:0] e_rd;
    logic [1:0] e_kind;
    logic [2:0] e_sx;

    // Expected outputs for the current inputs and model queue.
    function automatic void model_eval();
        bit rdy, dly, raw, waw, full, port;
        rdy    = (mq.size() > 0) && (mq[0].ready <= cyc);
        e_wb   = rdy && !bus.flush;
        e_rd   = (mq.size() > 0) ? mq[0].rd : 5'd0;
        e_kind = (mq.size() > 0) ? mq[0].kind : 2'd0;
        e_sx   = (mq.size() > 0) ? mq[0].sx : 3'd0;
        dly    = (bus.issue_kind == 2'b01) || (bus.issue_kind == 2'b10);
        raw    = 1'b0;
        waw    = 1'b0;
        foreach (mq[j]) begin
            if (!(BYP && j == 0 && rdy)) begin
                if (bus.issue_use_rs1 && bus.issue_rs1 != 0
                    && mq[j].rd == bus.issue_rs1) raw = 1'b1;
                if (bus.issue_use_rs2 && bus.issue_rs2 != 0
                    && mq[j].rd == bus.issue_rs2) raw = 1'b1;
                if (bus.issue_we && bus.issue_rd != 0
                    && mq[j].rd == bus.issue_rd) waw = 1'b1;
            end
        end
        full    = dly && (mq.size() == DEPTH) && !(BYP && rdy);
        port    = !dly && bus.issue_we && rdy;
        e_stall = bus.issue_valid && !bus.flush
               && (raw || waw || full || port);
    endfunction

    task automatic step();
        bit dly;
        @(posedge clk);
        model_eval();
        dly = (bus.issue_kind == 2'b01) || (bus.issue_kind == 2'b10);
        if (bus.flush) begin
            mq.delete();
        end else begin
            if (e_wb) mq.delete(0);
            if (bus.issue_valid && !e_stall && bus.issue_we
                && bus.issue_rd != 0 && dly)
                mq.push_back('{bus.issue_rd, bus.issue_kind,
                    bus.issue_sx_size,
                    cyc + ((bus.issue_kind == 2'b01) ? LL : CL)});
        end
        cyc++;
        #1;
    endtask

    task automatic drive(input bit v, input logic [1:0] k,
                         input bit we, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2,
                         input bit u1, input bit u2);
        bus.issue_valid   = v;
        bus.issue_kind    = k;
        bus.issue_we      = we;
        bus.issue_rd      = rd;
        bus.issue_rs1     = rs1;
        bus.issue_rs2     = rs2;
        bus.issue_use_rs1 = u1;
        bus.issue_use_rs2 = u2;
        bus.issue_sx_size = 3'b100;
    endtask

    task automatic idle();
        drive(0, 2'b00, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        bus.flush = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle();
        #1;
        checks++;
        if (bus.stall !== 1'b0) begin
            fails++; $display("FAIL reset_stall: got %b expected 0", bus.stall);
        end
        checks++;
        if (bus.wb_valid !== 1'b0) begin
            fails++; $display("FAIL reset_wb_valid: got %b expected 0", bus.wb_valid);
        end
        checks++;
        if (bus.wb_rd !== 5'd0 || bus.wb_kind !== 2'd0 || bus.wb_sx_size !== 3'd0) begin
            fails++;
            $display("FAIL reset_wb_fields: got %h/%h/%h expected 0/0/0",
                     bus.wb_rd, bus.wb_kind, bus.wb_sx_size);
        end
        checks++;
        if (bus.count !== CW'(0)) begin
            fails++; $display("FAIL reset_count: got %0d expected 0", bus.count);
        end
        @(negedge clk);
        rst = 1'b1;
        step();
    endtask

    task automatic test_raw_load();
        drive(1, 2'b01, 1, 5'd5, 5'd0, 5'd0, 0, 0);
        @(negedge clk);
        checks++;
        if (bus.stall !== 1'b0) begin
            fails++; $display("FAIL raw_load_issue: got %b expected 0", bus.stall);
        end
        step();
        drive(1, 2'b00, 1, 5'd6, 5'd5, 5'd1, 1, 1);
        @(negedge clk);
        checks++;
        if (bus.wb_valid !== 1'b1 || bus.wb_rd !== 5'd5) begin
            fails++;
            $display("FAIL raw_wb: got valid=%b rd=%0d expected valid=1 rd=5",
                     bus.wb_valid, bus.wb_rd);
        end
        checks++;
        if (bus.wb_kind !== 2'b01 || bus.wb_sx_size !== 3'b100) begin
            fails++;
            $display("FAIL raw_wb_meta: got %b/%b expected 01/100",
                     bus.wb_kind, bus.wb_sx_size);
        end
        checks++;
        if (bus.stall !== 1'b1) begin
            fails++; $display("FAIL raw_stall: got %b expected 1", bus.stall);
        end
        step();
        @(negedge clk);
        checks++;
        if (bus.stall !== 1'b0 || bus.wb_valid !== 1'b0) begin
            fails++;
            $display("FAIL raw_accept: got stall=%b wb=%b expected 0/0",
                     bus.stall, bus.wb_valid);
        end
        step();
        idle();
    endtask

    task automatic test_in_order();
        drive(1, 2'b10, 1, 5'd7, 5'd0, 5'd0, 0, 0);
        step();
        drive(1, 2'b01, 1, 5'd8, 5'd0, 5'd0, 0, 0);
        @(negedge clk);
        checks++;
        if (bus.stall !== 1'b0) begin
            fails++; $display("FAIL order_issue: got %b expected 0", bus.stall);
        end
        step();
        idle();
        for (int k = 2; k <= CL + 2; k++) begin
            @(negedge clk);
            checks++;
            if (bus.wb_valid !== (k == CL || k == CL + 1)) begin
                fails++;
                $display("FAIL order_wb_valid[%0d]: got %b expected %b",
                         k, bus.wb_valid, (k == CL || k == CL + 1));
            end
            if (k == CL || k == CL + 1) begin
                checks++;
                if (bus.wb_rd !== ((k == CL) ? 5'd7 : 5'd8)) begin
                    fails++;
                    $display("FAIL order_wb_rd[%0d]: got %0d expected %0d",
                             k, bus.wb_rd, (k == CL) ? 7 : 8);
                end
            end
            step();
        end
    endtask

    task automatic test_full();
        int first_wb = -1;
        int acc      = -1;
        for (int k = 0; k < 4; k++) begin
            drive(1, 2'b10, 1, 5'(k + 1), 5'd0, 5'd0, 0, 0);
            @(negedge clk);
            checks++;
            if (bus.stall !== 1'b0) begin
                fails++; $display("FAIL full_fill[%0d]: got %b expected 0", k, bus.stall);
            end
            step();
        end
        drive(1, 2'b01, 1, 5'd9, 5'd0, 5'd0, 0, 0);
        for (int k = 4; k < 30 && acc < 0; k++) begin
            @(negedge clk);
            if (bus.wb_valid && first_wb < 0) first_wb = k;
            if (k < CL) begin
                checks++;
                if (bus.stall !== 1'b1 || bus.count !== CW'(4)) begin
                    fails++;
                    $display("FAIL full_hold[%0d]: got stall=%b count=%0d expected 1/4",
                             k, bus.stall, bus.count);
                end
            end
            if (!bus.stall) acc = k;
            step();
        end
        idle();
        checks++;
        if (first_wb != CL) begin
            fails++; $display("FAIL full_first_wb: got %0d expected %0d", first_wb, CL);
        end
        checks++;
        if (acc != (BYP ? CL : CL + 1)) begin
            fails++;
            $display("FAIL full_accept: got %0d expected %0d", acc, BYP ? CL : CL + 1);
        end
        for (int k = 0; k < 40 && mq.size() > 0; k++) step();
        @(negedge clk);
        checks++;
        if (bus.count !== CW'(0)) begin
            fails++; $display("FAIL full_drain: got %0d expected 0", bus.count);
        end
        step();
    endtask

    task automatic test_port_conflict();
        drive(1, 2'b01, 1, 5'd11, 5'd0, 5'd0, 0, 0);
        step();
        drive(1, 2'b00, 1, 5'd10, 5'd0, 5'd0, 1, 0);
        @(negedge clk);
        checks++;
        if (bus.wb_valid !== 1'b1 || bus.wb_rd !== 5'd11) begin
            fails++;
            $display("FAIL port_wb: got valid=%b rd=%0d expected 1/11",
                     bus.wb_valid, bus.wb_rd);
        end
        checks++;
        if (bus.stall !== 1'b1) begin
            fails++; $display("FAIL port_stall: got %b expected 1", bus.stall);
        end
        step();
        @(negedge clk);
        checks++;
        if (bus.stall !== 1'b0 || bus.wb_valid !== 1'b0 || bus.count !== CW'(0)) begin
            fails++;
            $display("FAIL port_accept: got stall=%b wb=%b count=%0d expected 0/0/0",
                     bus.stall, bus.wb_valid, bus.count);
        end
        step();
        idle();
    endtask

    task automatic test_flush();
        drive(1, 2'b10, 1, 5'd12, 5'd0, 5'd0, 0, 0);
        step();
        drive(1, 2'b01, 1, 5'd13, 5'd0, 5'd0, 0, 0);
        step();
        idle();
        for (int k = 2; k < CL; k++) step();
        drive(1, 2'b01, 1, 5'd14, 5'd0, 5'd0, 0, 0);
        bus.flush = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.count !== CW'(2)) begin
            fails++; $display("FAIL flush_pending: got %0d expected 2", bus.count);
        end
        checks++;
        if (bus.wb_valid !== 1'b0 || bus.stall !== 1'b0) begin
            fails++;
            $display("FAIL flush_force: got wb=%b stall=%b expected 0/0",
                     bus.wb_valid, bus.stall);
        end
        step();
        bus.flush = 1'b0;
        drive(1, 2'b00, 0, 5'd0, 5'd12, 5'd13, 1, 1);
        @(negedge clk);
        checks++;
        if (bus.count !== CW'(0) || bus.stall !== 1'b0) begin
            fails++;
            $display("FAIL flush_after: got count=%0d stall=%b expected 0/0",
                     bus.count, bus.stall);
        end
        step();
        idle();
        for (int k = 0; k < CL + 2; k++) begin
            @(negedge clk);
            checks++;
            if (bus.wb_valid !== 1'b0) begin
                fails++; $display("FAIL flush_no_wb[%0d]: got %b expected 0", k, bus.wb_valid);
            end
            step();
        end
    endtask

    task automatic test_async_reset();
        for (int k = 0; k < 3; k++) begin
            drive(1, 2'b10, 1, 5'(k + 1), 5'd0, 5'd0, 0, 0);
            step();
        end
        drive(1, 2'b00, 0, 5'd0, 5'd1, 5'd0, 1, 0);
        @(negedge clk);
        checks++;
        if (bus.stall !== 1'b1 || bus.count !== CW'(3)) begin
            fails++;
            $display("FAIL areset_before: got stall=%b count=%0d expected 1/3",
                     bus.stall, bus.count);
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (bus.count !== CW'(0) || bus.stall !== 1'b0 || bus.wb_valid !== 1'b0) begin
            fails++;
            $display("FAIL areset_now: got count=%0d stall=%b wb=%b expected 0/0/0",
                     bus.count, bus.stall, bus.wb_valid);
        end
        mq.delete();
        #1;
        rst = 1'b1;
        step();
        idle();
        step();
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            bus.issue_valid   = ($urandom_range(0, 3) != 0);
            bus.issue_kind    = 2'($urandom_range(0, 3));
            bus.issue_we      = ($urandom_range(0, 4) != 0);
            bus.issue_rd      = 5'($urandom_range(0, 7));
            bus.issue_rs1     = 5'($urandom_range(0, 7));
            bus.issue_rs2     = 5'($urandom_range(0, 7));
            bus.issue_use_rs1 = 1'($urandom_range(0, 1));
            bus.issue_use_rs2 = 1'($urandom_range(0, 1));
            bus.issue_sx_size = 3'($urandom_range(0, 4));
            bus.flush         = ($urandom_range(0, 31) == 0);
            @(negedge clk);
            model_eval();
            checks++;
            if (bus.stall !== e_stall) begin
                fails++; $display("FAIL rnd_stall[%0d]: got %b expected %b", n, bus.stall, e_stall);
            end
            checks++;
            if (bus.wb_valid !== e_wb) begin
                fails++; $display("FAIL rnd_wb_valid[%0d]: got %b expected %b", n, bus.wb_valid, e_wb);
            end
            checks++;
            if (bus.count !== CW'(mq.size())) begin
                fails++; $display("FAIL rnd_count[%0d]: got %0d expected %0d", n, bus.count, mq.size());
            end
            if (e_wb) begin
                checks++;
                if (bus.wb_rd !== e_rd || bus.wb_kind !== e_kind || bus.wb_sx_size !== e_sx) begin
                    fails++;
                    $display("FAIL rnd_wb_data[%0d]: got %0d/%b/%b expected %0d/%b/%b",
                             n, bus.wb_rd, bus.wb_kind, bus.wb_sx_size, e_rd, e_kind, e_sx);
                end
            end
            step();
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_raw_load();
        test_in_order();
        test_full();
        test_port_conflict();
        test_flush();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
